// File: rtl/ps2_pkg.sv
// Shared constants, FSM state and byte-class types for the PS/2 scan-code decoder.
// The classification rules for one scan-code byte live here as pure functions.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } ps2_state_t;

    typedef enum logic [2:0] {
        CLS_EXT    = 3'd0,
        CLS_BRK    = 3'd1,
        CLS_ERR    = 3'd2,
        CLS_BREAK  = 3'd3,
        CLS_REPEAT = 3'd4,
        CLS_MAKE   = 3'd5
    } ps2_class_t;

    // A key is identified by its code together with the extended flag.
    function automatic logic ps2_same_key(
        input logic [7:0] b,
        input logic       ext_pend,
        input logic       key_ext,
        input logic [7:0] key_code
    );
        return ({ext_pend, b} == {key_ext, key_code});
    endfunction

    function automatic ps2_class_t ps2_classify(
        input logic [7:0] b,
        input logic       ext_pend,
        input logic       brk_pend,
        input logic       key_pressed,
        input logic       key_ext,
        input logic [7:0] key_code
    );
        ps2_class_t cls;
        if (b == PS2_EXT)
            cls = CLS_EXT;
        else if (b == PS2_BRK)
            cls = CLS_BRK;
        else if (b == PS2_ERR0 || b == PS2_ERR1)
            cls = CLS_ERR;
        else if (brk_pend)
            cls = CLS_BREAK;
        else if (key_pressed && ps2_same_key(b, ext_pend, key_ext, key_code))
            cls = CLS_REPEAT;
        else
            cls = CLS_MAKE;
        return cls;
    endfunction

endpackage

// File: rtl/ps2_fifo_pop.sv
// FIFO pop handshake: IDLE -> POP -> GAP, one byte per three cycles.
// byte_take marks the edge at which the head byte is consumed by the decoder.
module ps2_fifo_pop
    import ps2_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic ready,
    output logic nextdata_n,
    output logic byte_take
);

    ps2_state_t state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            nextdata_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ready) begin
                        state      <= POP;
                        nextdata_n <= 1'b0;
                    end
                end
                POP: begin
                    state      <= GAP;
                    nextdata_n <= 1'b1;
                end
                // GAP lets the FIFO read pointer and ready settle before the next sample.
                GAP: begin
                    state      <= IDLE;
                    nextdata_n <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    nextdata_n <= 1'b1;
                end
            endcase
        end
    end

    assign byte_take = (state == IDLE) && ready;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: pops bytes from the keyboard FIFO, tracks E0/F0 prefixes, emits events.
// Optional feature macro PS2_DEC_TYPEMATIC_EN drives repeat_pulse on typematic repeats.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_pressed,
    output logic             make_pulse,
    output logic             break_pulse,
    output logic             repeat_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             ovf_flag
);

    logic       byte_take;
    logic       ext_pend;
    logic       brk_pend;
    logic       same_key;
    ps2_class_t cls;

    ps2_fifo_pop u_pop (
        .clock      (clock),
        .reset      (reset),
        .ready      (ready),
        .nextdata_n (nextdata_n),
        .byte_take  (byte_take)
    );

    assign same_key = ps2_same_key(data, ext_pend, key_ext, key_code);
    assign cls      = ps2_classify(data, ext_pend, brk_pend, key_pressed, key_ext, key_code);

    // Results are registered at the sampling edge, so pulses line up with the POP cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_pend     <= 1'b0;
            brk_pend     <= 1'b0;
            key_code     <= 8'h00;
            key_ext      <= 1'b0;
            key_pressed  <= 1'b0;
            make_pulse   <= 1'b0;
            break_pulse  <= 1'b0;
            press_count  <= '0;
            ovf_flag     <= 1'b0;
`ifdef PS2_DEC_TYPEMATIC_EN
            repeat_pulse <= 1'b0;
`endif
        end else begin
            make_pulse   <= 1'b0;
            break_pulse  <= 1'b0;
`ifdef PS2_DEC_TYPEMATIC_EN
            repeat_pulse <= 1'b0;
`endif
            if (overflow)
                ovf_flag <= 1'b1;

            if (byte_take) begin
                case (cls)
                    CLS_EXT: ext_pend <= 1'b1;
                    CLS_BRK: brk_pend <= 1'b1;
                    CLS_ERR: begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                    // A break for a key other than the held one leaves the held key alone.
                    CLS_BREAK: begin
                        break_pulse <= 1'b1;
                        if (same_key)
                            key_pressed <= 1'b0;
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                    CLS_REPEAT: begin
`ifdef PS2_DEC_TYPEMATIC_EN
                        repeat_pulse <= 1'b1;
`endif
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                    CLS_MAKE: begin
                        key_code    <= data;
                        key_ext     <= ext_pend;
                        key_pressed <= 1'b1;
                        make_pulse  <= 1'b1;
                        press_count <= press_count + CNT_W'(1);
                        ext_pend    <= 1'b0;
                        brk_pend    <= 1'b0;
                    end
                    default: begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifndef PS2_DEC_TYPEMATIC_EN
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: FIFO emulation, key-event reference model, directed and random bytes.
`timescale 1ns/1ps
module tb_ps2_scan_decoder;

    localparam int CNT_W = 8;
`ifdef PS2_DEC_TYPEMATIC_EN
    localparam bit TYPEMATIC = 1'b1;
`else
    localparam bit TYPEMATIC = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             ready;
    logic [7:0]       data;
    logic             overflow;
    logic             nextdata_n;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_pressed;
    logic             make_pulse;
    logic             break_pulse;
    logic             repeat_pulse;
    logic [CNT_W-1:0] press_count;
    logic             ovf_flag;

    ps2_scan_decoder #(.CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .ready        (ready),
        .data         (data),
        .overflow     (overflow),
        .nextdata_n   (nextdata_n),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_pressed  (key_pressed),
        .make_pulse   (make_pulse),
        .break_pulse  (break_pulse),
        .repeat_pulse (repeat_pulse),
        .press_count  (press_count),
        .ovf_flag     (ovf_flag)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a key is the integer ext*256 + code.
    bit  m_ext, m_brk, m_pressed, m_ovf;
    int  m_key, m_cnt;
    bit  e_make, e_break, e_rep;

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_pressed = 0; m_ovf = 0; m_key = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input byte unsigned b);
        int id;
        id = (m_ext ? 256 : 0) + int'(b);
        e_make = 0; e_break = 0; e_rep = 0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (b == 8'h00 || b == 8'hFF) begin
            end else if (m_brk) begin
                e_break = 1;
                if (id == m_key) m_pressed = 0;
            end else if (m_pressed && id == m_key) begin
                e_rep = 1;
            end else begin
                e_make = 1;
                m_key = id;
                m_pressed = 1;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    byte unsigned fifo[$];
    int  lows[$];
    int  cyc = 0;
    int  n_make = 0, n_break = 0, n_rep = 0;
    bit  prev_low = 0;
    byte unsigned cur;

    // FIFO emulation and per-byte checking, all on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            prev_low = 0;
        end else begin
            if (make_pulse)   n_make++;
            if (break_pulse)  n_break++;
            if (repeat_pulse) n_rep++;
            if (nextdata_n == 1'b0) begin
                lows.push_back(cyc);
                check_val("pop_width", 32'(prev_low), 32'(0));
                if (fifo.size() > 0) begin
                    cur = fifo.pop_front();
                    model_step(cur);
                    check_val("make_pulse",   32'(make_pulse),   32'(e_make));
                    check_val("break_pulse",  32'(break_pulse),  32'(e_break));
                    check_val("repeat_pulse", 32'(repeat_pulse), 32'(e_rep & TYPEMATIC));
                    check_val("key_code",     32'(key_code),     32'(m_key[7:0]));
                    check_val("key_ext",      32'(key_ext),      32'(m_key[8]));
                    check_val("key_pressed",  32'(key_pressed),  32'(m_pressed));
                    check_val("press_count",  32'(press_count),  32'(m_cnt));
                    check_val("ovf_flag",     32'(ovf_flag),     32'(m_ovf));
                end else begin
                    check_val("pop_without_data", 32'(nextdata_n), 32'(1));
                end
            end else begin
                check_val("idle_pulses", 32'({make_pulse, break_pulse, repeat_pulse}), 32'(0));
            end
            prev_low = !nextdata_n;
        end
        ready = (fifo.size() > 0);
        if (fifo.size() > 0) data = fifo[0];
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_nextdata_n"},  32'(nextdata_n), 32'(1));
        check_val({tag, "_key_code"},    32'(key_code), 32'(0));
        check_val({tag, "_key_ext"},     32'(key_ext), 32'(0));
        check_val({tag, "_key_pressed"}, 32'(key_pressed), 32'(0));
        check_val({tag, "_pulses"},      32'({make_pulse, break_pulse, repeat_pulse}), 32'(0));
        check_val({tag, "_press_count"}, 32'(press_count), 32'(0));
        check_val({tag, "_ovf_flag"},    32'(ovf_flag), 32'(0));
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        model_reset();
        fifo.delete();
        #1 check_reset_outputs(tag);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        lows.delete();
        n_make = 0; n_break = 0; n_rep = 0;
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (fifo.size() != 0 && k < limit) begin
            @(negedge clock);
            k++;
        end
        repeat (3) @(negedge clock);
        if (k >= limit) check_val("drain_timeout", 32'(fifo.size()), 32'(0));
    endtask

    task automatic clear_counts();
        n_make = 0; n_break = 0; n_rep = 0;
    endtask

    byte unsigned pool [12] = '{8'hE0, 8'hF0, 8'h00, 8'hFF, 8'h1C, 8'h1B,
                                8'h75, 8'h12, 8'h1C, 8'h1B, 8'hF0, 8'hE0};

    initial begin
        int k;
        ready = 1'b0; data = 8'h00; overflow = 1'b0;
        @(negedge clock);
        apply_reset("rst0");

        // Simple make / break
        clear_counts();
        fifo.push_back(8'h1C); fifo.push_back(8'hF0); fifo.push_back(8'h1C);
        wait_drain(200);
        check_val("t1_makes",   32'(n_make), 32'(1));
        check_val("t1_breaks",  32'(n_break), 32'(1));
        check_val("t1_code",    32'(key_code), 32'(8'h1C));
        check_val("t1_pressed", 32'(key_pressed), 32'(0));
        check_val("t1_count",   32'(press_count), 32'(1));

        // Extended make / break
        clear_counts();
        fifo.push_back(8'hE0); fifo.push_back(8'h75);
        fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
        wait_drain(200);
        check_val("t2_makes",   32'(n_make), 32'(1));
        check_val("t2_breaks",  32'(n_break), 32'(1));
        check_val("t2_code",    32'(key_code), 32'(8'h75));
        check_val("t2_ext",     32'(key_ext), 32'(1));
        check_val("t2_pressed", 32'(key_pressed), 32'(0));

        // Typematic repeat
        clear_counts();
        fifo.push_back(8'h1B); fifo.push_back(8'h1B); fifo.push_back(8'h1B);
        fifo.push_back(8'hF0); fifo.push_back(8'h1B);
        wait_drain(200);
        check_val("t3_makes",   32'(n_make), 32'(1));
        check_val("t3_breaks",  32'(n_break), 32'(1));
        check_val("t3_repeats", 32'(n_rep), 32'(TYPEMATIC ? 2 : 0));
        check_val("t3_count",   32'(press_count), 32'(3));

        // Pop strobe spacing with ready held high
        apply_reset("rst1");
        fifo.push_back(8'h1C); fifo.push_back(8'h1B); fifo.push_back(8'h12); fifo.push_back(8'hF0);
        wait_drain(200);
        check_val("t4_pops", 32'(lows.size()), 32'(4));
        for (int i = 1; i < lows.size(); i++)
            check_val("t4_spacing", 32'(lows[i] - lows[i-1]), 32'(3));

        // Overflow stickiness and counter wrap
        apply_reset("rst2");
        overflow = 1'b1;
        @(negedge clock);
        overflow = 1'b0;
        m_ovf = 1;
        @(negedge clock);
        check_val("t5_ovf_set", 32'(ovf_flag), 32'(1));
        for (int i = 0; i < 256; i++) fifo.push_back((i % 2 == 0) ? 8'h1C : 8'h1B);
        wait_drain(5000);
        check_val("t5_wrap", 32'(press_count), 32'(0));
        check_val("t5_ovf_sticky", 32'(ovf_flag), 32'(1));

        // Reset during the POP cycle of an F0
        apply_reset("rst3");
        fifo.push_back(8'hF0);
        k = 0;
        while (nextdata_n !== 1'b0 && k < 50) begin
            @(negedge clock);
            k++;
        end
        check_val("t6_pop_seen", 32'(nextdata_n), 32'(0));
        #2 apply_reset("rst_pop");
        fifo.push_back(8'h1C);
        wait_drain(200);
        check_val("t6_makes",   32'(n_make), 32'(1));
        check_val("t6_breaks",  32'(n_break), 32'(0));
        check_val("t6_pressed", 32'(key_pressed), 32'(1));

        // Random byte stream against the model
        apply_reset("rst4");
        for (int i = 0; i < 400; i++) begin
            fifo.push_back(pool[$urandom_range(0, 11)]);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clock);
        end
        wait_drain(5000);
        check_val("rand_count",   32'(press_count), 32'(m_cnt));
        check_val("rand_pressed", 32'(key_pressed), 32'(m_pressed));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule
